// File: rtl/fifo2wb_pkg.sv
// Shared types and Wishbone constants for the FIFO-to-Wishbone write master.
package fifo2wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        REQ,
        BACKOFF,
        DONE
    } state_e;

    localparam logic [2:0]  WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0]  WB_BTE_LINEAR  = 2'b00;
    localparam logic [3:0]  WB_SEL_ALL     = 4'hF;
    localparam logic [31:0] ADDR_STEP      = 32'd4;

endpackage

// File: rtl/fifo2wb_watchdog.sv
// Cycle counter that flags when a bus request has been outstanding for LIMIT cycles.
module fifo2wb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic wb_clk_i,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds the number of completed REQ cycles, so the Nth cycle expires.
    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo2wb_master.sv
// Drains a FWFT FIFO into single-word Wishbone classic write cycles (simple DMA).
module fifo2wb_master
    import fifo2wb_pkg::*;
#(
    parameter int FT_DATA_WIDTH  = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3
) (
    input  logic                     wb_clk_i,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [31:0]              base_adr_i,
    input  logic [LEN_WIDTH-1:0]     len_i,
    input  logic                     addr_inc_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [LEN_WIDTH-1:0]     words_done_o,
    output logic                     fifoin_clk_o,
    input  logic [FT_DATA_WIDTH-1:0] fifoin_data_i,
    input  logic                     fifoin_empty_i,
    output logic                     fifoin_rd_o,
    output logic [31:0]              wb_adr_o,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_we_o,
    output logic [3:0]               wb_sel_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic [2:0]               wb_cti_o,
    output logic [1:0]               wb_bte_o,
    output logic                     wb_lock_o,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    input  logic                     wb_rty_i
);

    localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

    state_e                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [LEN_WIDTH-1:0]     words_q, words_d;
    logic [31:0]              adr_q, adr_d;
    logic [FT_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]               retry_q, retry_d;
    logic                     inc_q, inc_d;
    logic                     error_q, error_d;
    logic                     rd;
    logic                     expire;
    logic [7:0]               retry_inc;
    logic [LEN_WIDTH-1:0]     words_inc;

    logic                     cyc_q, stb_q, we_q, busy_q, done_q;
    logic [3:0]               sel_q;

    assign retry_inc = retry_q + 8'd1;
    assign words_inc = words_q + 1'b1;

    fifo2wb_watchdog #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_watchdog (
        .wb_clk_i (wb_clk_i),
        .rst      (rst),
        .clr_i    (state_q != REQ),
        .en_i     (state_q == REQ),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        retry_d = retry_q;
        inc_d   = inc_q;
        error_d = error_q;
        rd      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        len_d   = len_i;
                        inc_d   = addr_inc_i;
                        adr_d   = {base_adr_i[31:2], 2'b00};
                        words_d = '0;
                        error_d = 1'b0;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (abort_i) begin
                    state_d = DONE;
                end else if (!fifoin_empty_i) begin
                    rd      = 1'b1;
                    wdata_d = fifoin_data_i;
                    retry_d = 8'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // err outranks a simultaneous ack: the word is not counted.
                if (wb_err_i) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (wb_ack_i) begin
                    words_d = words_inc;
                    if (inc_q) begin
                        adr_d = adr_q + ADDR_STEP;
                    end
                    state_d = ((words_inc == len_q) || abort_i) ? DONE : FETCH;
                end else if (wb_rty_i) begin
                    retry_d = retry_inc;
                    if (retry_inc > RETRY_LIM) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BACKOFF;
                    end
                end else if (expire) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            BACKOFF: state_d = REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus and status outputs are registered from the next state, so they track state_q.
    always_ff @(posedge wb_clk_i or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            words_q <= '0;
            adr_q   <= 32'd0;
            wdata_q <= '0;
            retry_q <= 8'd0;
            inc_q   <= 1'b0;
            error_q <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            retry_q <= retry_d;
            inc_q   <= inc_d;
            error_q <= error_d;
            cyc_q   <= (state_d == REQ);
            stb_q   <= (state_d == REQ);
            we_q    <= (state_d == REQ);
            sel_q   <= (state_d == REQ) ? WB_SEL_ALL : 4'h0;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign fifoin_clk_o = wb_clk_i;
    assign fifoin_rd_o  = rd;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign words_done_o = words_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = wdata_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb_q;
    assign wb_cti_o     = WB_CTI_CLASSIC;
    assign wb_bte_o     = WB_BTE_LINEAR;
    assign wb_lock_o    = 1'b0;

endmodule

// File: tb/tb_fifo2wb_master.sv
// Self-checking bench: FWFT FIFO model, scripted Wishbone slave and a transfer-level reference model.
module tb_fifo2wb_master;

    localparam int LW   = 16;
    localparam int TO   = 20;
    localparam int RMAX = 3;

    // Slave response codes
    localparam int R_ACK = 0, R_ERR = 1, R_RTY = 2, R_ACKERR = 3, R_NONE = 4;

    logic          wb_clk_i = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [31:0]   base_adr_i = 32'd0;
    logic [LW-1:0] len_i = '0;
    logic          addr_inc_i = 1'b0;
    logic          busy_o, done_o, error_o;
    logic [LW-1:0] words_done_o;
    logic          fifoin_clk_o;
    logic [31:0]   fifoin_data_i = 32'd0;
    logic          fifoin_empty_i = 1'b1;
    logic          fifoin_rd_o;
    logic [31:0]   wb_adr_o, wb_dat_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_lock_o;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    fifo2wb_master #(
        .FT_DATA_WIDTH (32),
        .LEN_WIDTH     (LW),
        .TIMEOUT_CYCLES(TO),
        .RETRY_MAX     (RMAX)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .base_adr_i    (base_adr_i),
        .len_i         (len_i),
        .addr_inc_i    (addr_inc_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .words_done_o  (words_done_o),
        .fifoin_clk_o  (fifoin_clk_o),
        .fifoin_data_i (fifoin_data_i),
        .fifoin_empty_i(fifoin_empty_i),
        .fifoin_rd_o   (fifoin_rd_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_we_o       (wb_we_o),
        .wb_sel_o      (wb_sel_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_cti_o      (wb_cti_o),
        .wb_bte_o      (wb_bte_o),
        .wb_lock_o     (wb_lock_o),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i),
        .wb_rty_i      (wb_rty_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // FWFT FIFO: head word presented at negedge, pop applied just after the edge that consumed it.
    logic [31:0] fifo_q[$];
    int          pops = 0;

    initial begin : fifo_proc
        bit pend;
        forever begin
            @(negedge wb_clk_i);
            fifoin_empty_i = (fifo_q.size() == 0);
            fifoin_data_i  = (fifo_q.size() == 0) ? 32'd0 : fifo_q[0];
            #1 pend = fifoin_rd_o;
            @(posedge wb_clk_i);
            #1;
            if (pend && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            fifoin_empty_i = (fifo_q.size() == 0);
            fifoin_data_i  = (fifo_q.size() == 0) ? 32'd0 : fifo_q[0];
        end
    end

    // Scripted slave: answers each strobe one cycle after it is first seen.
    int          resp_q[$];
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int          stb_starts = 0;
    int          stb_cycles = 0;

    initial begin : slave_proc
        bit prev;
        bit responded;
        int wc;
        int code;
        prev = 0; responded = 0; wc = 0; code = R_ACK;
        forever begin
            @(negedge wb_clk_i);
            if (rst && wb_cyc_o && wb_stb_o) begin
                stb_cycles++;
                if (!prev) begin
                    stb_starts++;
                    wc = 0;
                    responded = 0;
                    code = (resp_q.size() > 0) ? resp_q.pop_front() : R_ACK;
                end
                wc++;
                if (!responded && wc == 2 && code != R_NONE) begin
                    responded = 1;
                    wb_ack_i = (code == R_ACK) || (code == R_ACKERR);
                    wb_err_i = (code == R_ERR) || (code == R_ACKERR);
                    wb_rty_i = (code == R_RTY);
                    if (code == R_ACK) begin
                        wr_adr.push_back(wb_adr_o);
                        wr_dat.push_back(wb_dat_o);
                    end
                end
                prev = 1;
            end else begin
                wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
                prev = 0;
            end
        end
    end

    // Transfer-level reference: walk words and slave answers, no cycle timing involved.
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    int          exp_words, exp_pops, exp_starts;
    bit          exp_err;

    function automatic void model(input logic [31:0] base, input int len, input bit inc,
                                  input logic [31:0] data[$], input int script[$]);
        logic [31:0] adr;
        int si, tries, code;
        bit fin;
        adr = {base[31:2], 2'b00};
        exp_adr.delete(); exp_dat.delete();
        exp_words = 0; exp_pops = 0; exp_starts = 0; exp_err = 0; si = 0;
        for (int w = 0; w < len && !exp_err; w++) begin
            logic [31:0] d;
            d = data[exp_pops];
            exp_pops++;
            tries = 0;
            fin = 0;
            while (!fin) begin
                code = (si < script.size()) ? script[si] : R_ACK;
                si++;
                exp_starts++;
                if (code == R_ACK) begin
                    exp_adr.push_back(adr);
                    exp_dat.push_back(d);
                    exp_words++;
                    if (inc) adr = adr + 32'd4;
                    fin = 1;
                end else if (code == R_RTY) begin
                    tries++;
                    if (tries > RMAX) begin exp_err = 1; fin = 1; end
                end else begin
                    exp_err = 1;
                    fin = 1;
                end
            end
        end
    endfunction

    task automatic clear_logs();
        wr_adr.delete(); wr_dat.delete();
        stb_starts = 0; stb_cycles = 0; pops = 0;
    endtask

    // Pulses start and waits for done; reports whether done arrived and how long it stayed high.
    task automatic run_xfer(input logic [31:0] base, input int len, input bit inc,
                            output bit ok, output int pw);
        @(posedge wb_clk_i);
        #1;
        base_adr_i = base; len_i = len[LW-1:0]; addr_inc_i = inc; start_i = 1;
        @(posedge wb_clk_i);
        #1 start_i = 0;
        ok = 0; pw = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge wb_clk_i);
            if (done_o) begin ok = 1; break; end
        end
        if (ok) begin
            pw = 1;
            for (int i = 0; i < 5; i++) begin
                @(negedge wb_clk_i);
                if (done_o) pw++; else break;
            end
        end
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(negedge wb_clk_i);
        n_checks++;
        if ({busy_o, done_o, error_o, wb_cyc_o, wb_stb_o, wb_we_o, fifoin_rd_o} !== 7'b0 ||
            words_done_o !== '0 || wb_adr_o !== 32'd0 || wb_sel_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b err=%b cyc=%b stb=%b we=%b rd=%b words=%0d adr=%h sel=%h, required all zero",
                     busy_o, done_o, error_o, wb_cyc_o, wb_stb_o, wb_we_o, fifoin_rd_o, words_done_o, wb_adr_o, wb_sel_o);
        end
        n_checks++;
        if (wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00 || wb_lock_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_consts: cti=%b bte=%b lock=%b, required 000/00/0", wb_cti_o, wb_bte_o, wb_lock_o);
        end
        @(posedge wb_clk_i);
        #3 rst = 1;
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_incr_burst();
        bit ok; int pw;
        clear_logs(); resp_q.delete();
        fifo_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        model(32'h1000, 4, 1, fifo_q, resp_q);
        run_xfer(32'h1000, 4, 1, ok, pw);
        n_checks++;
        if (!ok || pw != 1) begin n_fail++; $display("FAIL incr_done: seen=%0d width=%0d, required 1/1", ok, pw); end
        n_checks++;
        if (wr_adr.size() != 4) begin n_fail++; $display("FAIL incr_count: writes=%0d, required 4", wr_adr.size()); end
        for (int i = 0; i < 4 && i < wr_adr.size(); i++) begin
            n_checks++;
            if (wr_adr[i] !== exp_adr[i] || wr_dat[i] !== exp_dat[i]) begin
                n_fail++;
                $display("FAIL incr_write%0d: %h@%h, required %h@%h", i, wr_dat[i], wr_adr[i], exp_dat[i], exp_adr[i]);
            end
        end
        n_checks++;
        if (words_done_o !== 16'd4 || error_o !== 1'b0 || pops != 4 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_status: words=%0d err=%b pops=%0d busy=%b, required 4/0/4/0", words_done_o, error_o, pops, busy_o);
        end
        n_checks++;
        if (stb_cycles != 8) begin n_fail++; $display("FAIL incr_stb_cycles: %0d, required 8", stb_cycles); end
        $display("test_incr_burst: %0d writes, words_done=%0d", wr_adr.size(), words_done_o);
    endtask

    task automatic test_fixed_slow_fifo();
        bit ok; int pw;
        logic [31:0] data[$];
        clear_logs(); resp_q.delete(); fifo_q.delete();
        data = {32'hB0, 32'hB1, 32'hB2};
        model(32'h2003, 3, 0, data, resp_q);
        fork
            for (int i = 0; i < 3; i++) begin
                repeat (10) @(posedge wb_clk_i);
                #2 fifo_q.push_back(data[i]);
            end
        join_none
        run_xfer(32'h2003, 3, 0, ok, pw);
        n_checks++;
        if (!ok || wr_adr.size() != 3 || stb_starts != exp_starts) begin
            n_fail++;
            $display("FAIL fixed_done: seen=%0d writes=%0d strobes=%0d, required 1/3/%0d", ok, wr_adr.size(), stb_starts, exp_starts);
        end
        for (int i = 0; i < 3 && i < wr_adr.size(); i++) begin
            n_checks++;
            if (wr_adr[i] !== 32'h2000 || wr_dat[i] !== exp_dat[i]) begin
                n_fail++;
                $display("FAIL fixed_write%0d: %h@%h, required %h@00002000", i, wr_dat[i], wr_adr[i], exp_dat[i]);
            end
        end
        $display("test_fixed_slow_fifo: %0d writes, strobes=%0d", wr_adr.size(), stb_starts);
    endtask

    task automatic test_retry(input int n_rty);
        bit ok; int pw;
        clear_logs(); resp_q.delete();
        fifo_q = {32'hC0DE0000 + n_rty};
        for (int i = 0; i < n_rty; i++) resp_q.push_back(R_RTY);
        model(32'h3000, 1, 1, fifo_q, resp_q);
        run_xfer(32'h3000, 1, 1, ok, pw);
        n_checks++;
        if (!ok || pw != 1 || words_done_o !== exp_words[LW-1:0] || error_o !== exp_err) begin
            n_fail++;
            $display("FAIL retry%0d_status: done=%0d width=%0d words=%0d err=%b, required 1/1/%0d/%b",
                     n_rty, ok, pw, words_done_o, error_o, exp_words, exp_err);
        end
        n_checks++;
        if (stb_starts != exp_starts || pops != 1) begin
            n_fail++;
            $display("FAIL retry%0d_strobes: strobes=%0d pops=%0d, required %0d/1", n_rty, stb_starts, pops, exp_starts);
        end
        $display("test_retry(%0d rty): strobes=%0d words=%0d err=%b", n_rty, stb_starts, words_done_o, error_o);
    endtask

    task automatic test_timeout();
        bit ok; int pw;
        clear_logs(); resp_q = {R_NONE};
        fifo_q = {32'hDEAD0001, 32'hDEAD0002};
        run_xfer(32'h4000, 2, 1, ok, pw);
        n_checks++;
        if (!ok || stb_cycles != TO || error_o !== 1'b1 || words_done_o !== '0 || wb_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: done=%0d stb_cycles=%0d err=%b words=%0d stb=%b, required 1/%0d/1/0/0",
                     ok, stb_cycles, error_o, words_done_o, wb_stb_o, TO);
        end
        fifo_q.delete();
        $display("test_timeout: stb held %0d cycles, err=%b", stb_cycles, error_o);
    endtask

    task automatic test_ack_err();
        bit ok; int pw;
        clear_logs(); resp_q = {R_ACK, R_ACKERR};
        fifo_q = {32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        run_xfer(32'h5000, 5, 1, ok, pw);
        n_checks++;
        if (!ok || error_o !== 1'b1 || words_done_o !== 16'd1 || pops != 2) begin
            n_fail++;
            $display("FAIL ack_err: done=%0d err=%b words=%0d pops=%0d, required 1/1/1/2", ok, error_o, words_done_o, pops);
        end
        fifo_q.delete(); resp_q.delete();
        $display("test_ack_err: words=%0d pops=%0d err=%b", words_done_o, pops, error_o);
    endtask

    task automatic test_abort();
        bit ok; int pw;
        clear_logs(); resp_q.delete(); fifo_q.delete();
        fork
            begin repeat (4) @(posedge wb_clk_i); #1 abort_i = 1; end
        join_none
        run_xfer(32'h6000, 2, 1, ok, pw);
        abort_i = 0;
        n_checks++;
        if (!ok || error_o !== 1'b0 || words_done_o !== '0 || pops != 0 || stb_starts != 0) begin
            n_fail++;
            $display("FAIL abort_fetch: done=%0d err=%b words=%0d pops=%0d strobes=%0d, required 1/0/0/0/0",
                     ok, error_o, words_done_o, pops, stb_starts);
        end
        $display("test_abort: done=%0d strobes=%0d", ok, stb_starts);
    endtask

    task automatic test_reset_midcycle();
        bit ok, seen; int pw;
        clear_logs(); resp_q = {R_NONE};
        fifo_q = {32'h1, 32'h2, 32'h3, 32'h4};
        @(posedge wb_clk_i);
        #1 base_adr_i = 32'h7000; len_i = 16'd4; addr_inc_i = 1; start_i = 1;
        @(posedge wb_clk_i);
        #1 start_i = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge wb_clk_i);
            seen = wb_stb_o;
        end
        #2 rst = 0;
        #1;
        n_checks++;
        if (!seen || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: stb_seen=%0d cyc=%b stb=%b busy=%b, required 1/0/0/0", seen, wb_cyc_o, wb_stb_o, busy_o);
        end
        @(posedge wb_clk_i);
        #3 rst = 1;
        fifo_q.delete(); resp_q.delete();
        repeat (2) @(posedge wb_clk_i);
        clear_logs();
        run_xfer(32'h8000, 0, 1, ok, pw);
        n_checks++;
        if (!ok || pw != 1 || stb_starts != 0 || pops != 0) begin
            n_fail++;
            $display("FAIL len0_after_reset: done=%0d width=%0d strobes=%0d pops=%0d, required 1/1/0/0", ok, pw, stb_starts, pops);
        end
        $display("test_reset_midcycle: len0 done=%0d strobes=%0d", ok, stb_starts);
    endtask

    task automatic test_random();
        bit ok; int pw;
        for (int it = 0; it < 10; it++) begin
            int len;
            bit inc;
            logic [31:0] base;
            len  = $urandom_range(1, 6);
            inc  = 1'($urandom_range(0, 1));
            base = $urandom;
            clear_logs(); resp_q.delete(); fifo_q.delete();
            for (int i = 0; i < len; i++) fifo_q.push_back($urandom);
            for (int i = 0; i < 3 * len; i++) begin
                int r;
                r = $urandom_range(0, 99);
                resp_q.push_back(r < 70 ? R_ACK : r < 92 ? R_RTY : r < 96 ? R_ERR : R_ACKERR);
            end
            model(base, len, inc, fifo_q, resp_q);
            run_xfer(base, len, inc, ok, pw);
            n_checks++;
            if (!ok || words_done_o !== exp_words[LW-1:0] || error_o !== exp_err ||
                pops != exp_pops || stb_starts != exp_starts || wr_adr.size() != exp_adr.size()) begin
                n_fail++;
                $display("FAIL rand%0d_status: done=%0d words=%0d/%0d err=%b/%b pops=%0d/%0d strobes=%0d/%0d writes=%0d/%0d",
                         it, ok, words_done_o, exp_words, error_o, exp_err, pops, exp_pops,
                         stb_starts, exp_starts, wr_adr.size(), exp_adr.size());
            end
            for (int i = 0; i < wr_adr.size() && i < exp_adr.size(); i++) begin
                n_checks++;
                if (wr_adr[i] !== exp_adr[i] || wr_dat[i] !== exp_dat[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_write%0d: %h@%h, required %h@%h", it, i, wr_dat[i], wr_adr[i], exp_dat[i], exp_adr[i]);
                end
            end
            $display("test_random[%0d]: len=%0d inc=%0d words=%0d err=%b strobes=%0d", it, len, inc, words_done_o, error_o, stb_starts);
        end
        fifo_q.delete(); resp_q.delete();
    endtask

    initial begin
        test_reset();
        test_incr_burst();
        test_fixed_slow_fifo();
        test_retry(2);
        test_retry(4);
        test_timeout();
        test_ack_err();
        test_abort();
        test_reset_midcycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/fifo2wb_master.md
Name: fifo2wb_master

Overview:
- Wishbone B3 classic-cycle master that drains a first-word-fall-through FIFO into single-word Wishbone writes.
- It is the initiator-side counterpart to the FIFO-backed Wishbone slave bridge.
- Used as a simple DMA: moves FT-sourced samples to a memory or peripheral data register, at fixed or incrementing byte addresses.
- Control comes from sideband ports: start, base, length, increment mode. Status is reported on busy, done, error and count outputs.

Parameters:
- FT_DATA_WIDTH, 32, FIFO word width; must be 32 (matches wb_dat_o).
- LEN_WIDTH, 16, width of transfer length and word counter.
- TIMEOUT_CYCLES, 255, max cycles waiting for ack/err/rty before abort; range 1..255.
- RETRY_MAX, 3, rty responses tolerated per word before abort.

Ports:
- wb_clk_i  in  1  clock; also driven out on fifoin_clk_o.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  1-cycle start pulse; ignored while busy_o=1.
- abort_i  in  1  request abort; level, sampled every cycle.
- base_adr_i  in  32  start byte address; bits [1:0] forced to 0.
- len_i  in  LEN_WIDTH  number of words to transfer.
- addr_inc_i  in  1  1: address +4 per word; 0: fixed address.
- busy_o  out  1  transfer in progress.
- done_o  out  1  1-cycle pulse at end of transfer (normal, error or abort).
- error_o  out  1  sticky; cleared by the next accepted start.
- words_done_o  out  LEN_WIDTH  count of acked words in current/last transfer.
- fifoin_clk_o  out  1  equals wb_clk_i.
- fifoin_data_i  in  32  FWFT head word, valid while fifoin_empty_i=0.
- fifoin_empty_i  in  1  FIFO empty.
- fifoin_rd_o  out  1  pop strobe.
- wb_adr_o  out  32  byte address.
- wb_dat_o  out  32  write data.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte selects.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_cti_o  out  3  cycle type; constant 3'b000.
- wb_bte_o  out  2  burst type; constant 2'b00.
- wb_lock_o  out  1  lock; constant 0.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error termination.
- wb_rty_i  in  1  retry termination.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; all outputs 0, including wb_cyc_o and wb_stb_o, which drop immediately even mid-cycle. Counters, address and data registers clear to 0.
- All outputs are registered except fifoin_rd_o and fifoin_clk_o.
- IDLE:
  - start_i=1 with len_i!=0: latch base, len and inc; clear words_done_o and error_o; go FETCH; busy_o=1 next cycle.
  - start_i=1 with len_i==0: go DONE directly; no bus or FIFO activity.
- FETCH:
  - abort_i=1: go DONE.
  - Else if fifoin_empty_i=0: fifoin_rd_o=1 for exactly one cycle; latch fifoin_data_i into wdata; clear the retry and timeout counters; go REQ.
  - Else wait, with no timeout while waiting.
- REQ:
  - wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=4'hF, wb_adr_o=cur_adr, wb_dat_o=wdata.
  - Priority on the sampling edge: err > ack > rty > timeout.
  - err: set error_o; go DONE. The word is not counted.
  - ack: words_done_o+1; cur_adr += 4 if inc (wraps mod 2^32). If words_done_o+1==len or abort_i=1, go DONE; else go FETCH.
  - rty: retry_cnt+1. If it exceeds RETRY_MAX, set error_o and go DONE; else go BACKOFF.
  - Timeout counter reaches TIMEOUT_CYCLES: set error_o; go DONE.
  - abort_i does not cut an in-flight cycle short.
  - cyc/stb deassert the cycle after any termination; there is never a back-to-back stb without an intervening FETCH or BACKOFF cycle.
- BACKOFF: cyc=stb=0 for exactly one cycle; the same wdata is reissued; go REQ. The timeout counter resets on reissue.
- DONE: done_o=1 for one cycle; busy_o=0 next cycle; go IDLE.
- Latency:
  - start edge to first stb: 2 cycles if the FIFO is non-empty.
  - Per-word throughput with a slave that acks one cycle after stb: 3 cycles/word.
- Data popped but not acked (err, timeout, retry exhaustion) is discarded; software uses words_done_o to resume.

Decomposition:
- Package fifo2wb_pkg holds:
  - state enum: IDLE, FETCH, REQ, BACKOFF, DONE;
  - constants WB_CTI_CLASSIC=3'b000, WB_BTE_LINEAR=2'b00, WB_SEL_ALL=4'hF, ADDR_STEP=4.
- One sub-module, fifo2wb_watchdog: 8-bit cycle counter with clear and enable inputs and an expire output; used for the REQ timeout.

Test Plan:
- base=0x1000, len=4, inc=1, FIFO preloaded with 0xA0..0xA3, slave acks 1 cycle after stb -> writes 0xA0@0x1000, 0xA1@0x1004, 0xA2@0x1008, 0xA3@0x100C; 4 pops; done_o pulse; words_done_o=4; error_o=0.
- len=3, inc=0, base=0x2003, FIFO initially empty then one word every 10 cycles -> all 3 writes to 0x2000; no stb while empty; done after the third ack.
- Slave answers rty 2x then ack (RETRY_MAX=3) -> same data reissued 3 times, one BACKOFF cycle each; words_done_o=1; error_o=0. Answering rty 4x instead -> error_o=1, done_o pulse, words_done_o=0.
- Slave never responds, TIMEOUT_CYCLES=20 -> stb held 20 cycles, then cyc/stb=0, error_o=1, done_o pulse.
- ack and err asserted together on word 2 of len=5 -> error_o=1; words_done_o=1; exactly 2 pops.
- rst pulled low while stb=1 mid-transfer -> wb_cyc_o/wb_stb_o/busy_o=0 immediately; after release, a new start with len=0 gives a done_o pulse and no bus activity.
